// File: rtl/sevenseg_scan.sv
// sevenseg_scan: multiplexed seven-segment driver with frame-aligned double-buffered updates
module sevenseg_scan #(
  parameter int DIGITS = 4,
  parameter int CLK_DIV = 50000,
  parameter int BLANK_CYC = 16,
  parameter int ACTIVE_LOW = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   value_in,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic [DIGITS-1:0]     blank_in,
  input  logic                  lz_en,
  input  logic                  load,
  output logic                  update_pending,
  output logic                  frame_pulse,
  output logic [7:0]            seg_out,
  output logic [DIGITS-1:0]     an_out
);
  localparam int CW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
  localparam logic POL = ACTIVE_LOW != 0;
  localparam logic [6:0] LUT [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [4*DIGITS-1:0] cv_q, cv_d, pv_q, pv_d;
  logic [DIGITS-1:0] cdp_q, cdp_d, cbl_q, cbl_d, pdp_q, pdp_d, pbl_q, pbl_d, an_q, an_d;
  logic clz_q, clz_d, plz_q, plz_d, upd_q, upd_d, fp_q, fp_d;
  logic [7:0] seg_q, seg_d;
  logic tick, wrap, commit, hi_zero, dark, on;
  logic [3:0] nib;
  // Scan sequencing, buffer transfer and output decode from the current (pre-edge) state
  always_comb begin
    tick = cnt_q == CW'(CLK_DIV - 1);
    wrap = tick && idx_q == IW'(DIGITS - 1);
    commit = wrap && upd_q;
    cnt_d = tick ? '0 : cnt_q + 1'b1;
    idx_d = wrap ? '0 : tick ? idx_q + 1'b1 : idx_q;
    cv_d = commit ? pv_q : cv_q;
    cdp_d = commit ? pdp_q : cdp_q;
    cbl_d = commit ? pbl_q : cbl_q;
    clz_d = commit ? plz_q : clz_q;
    pv_d = load ? value_in : pv_q;
    pdp_d = load ? dp_in : pdp_q;
    pbl_d = load ? blank_in : pbl_q;
    plz_d = load ? lz_en : plz_q;
    upd_d = load || (upd_q && !wrap);
    fp_d = wrap;
    nib = cv_q[4*idx_q +: 4];
    hi_zero = (cv_q >> (4*idx_q)) == '0;
    dark = cbl_q[idx_q] || (clz_q && hi_zero && idx_q != '0);
    on = 32'(cnt_q) >= BLANK_CYC;
    seg_d = {8{POL}} ^ (dark || !on ? 8'h00 : {cdp_q[idx_q], LUT[nib]});
    an_d = {DIGITS{POL}} ^ (on ? DIGITS'(1) << idx_q : '0);
  end
  // State and registered pin outputs; reset discards both buffers and parks pins dark
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      idx_q <= '0;
      cv_q <= '0;
      cdp_q <= '0;
      cbl_q <= '0;
      clz_q <= 1'b0;
      pv_q <= '0;
      pdp_q <= '0;
      pbl_q <= '0;
      plz_q <= 1'b0;
      upd_q <= 1'b0;
      fp_q <= 1'b0;
      seg_q <= {8{POL}};
      an_q <= {DIGITS{POL}};
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      cv_q <= cv_d;
      cdp_q <= cdp_d;
      cbl_q <= cbl_d;
      clz_q <= clz_d;
      pv_q <= pv_d;
      pdp_q <= pdp_d;
      pbl_q <= pbl_d;
      plz_q <= plz_d;
      upd_q <= upd_d;
      fp_q <= fp_d;
      seg_q <= seg_d;
      an_q <= an_d;
    end
  end
  assign update_pending = upd_q;
  assign frame_pulse = fp_q;
  assign seg_out = seg_q;
  assign an_out = an_q;
endmodule

// File: tb/tb_sevenseg_scan.sv
// tb_sevenseg_scan: directed self-checking bench for sevenseg_scan (4 digits, 8-cycle slots, 2 blank)
module tb_sevenseg_scan;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [15:0] value_in = '0;
  logic [3:0] dp_in = '0, blank_in = '0;
  logic lz_en = 1'b0, load = 1'b0;
  logic update_pending, frame_pulse, upd2, fp2;
  logic [7:0] seg_out, seg2;
  logic [3:0] an_out, an2;
  logic upd_before;
  int ncmp = 0, nfail = 0;

  sevenseg_scan #(.DIGITS(4), .CLK_DIV(8), .BLANK_CYC(2), .ACTIVE_LOW(0)) dut (
    .clk(clk), .rst(rst), .value_in(value_in), .dp_in(dp_in), .blank_in(blank_in),
    .lz_en(lz_en), .load(load), .update_pending(update_pending), .frame_pulse(frame_pulse),
    .seg_out(seg_out), .an_out(an_out));

  sevenseg_scan #(.DIGITS(4), .CLK_DIV(8), .BLANK_CYC(2), .ACTIVE_LOW(1)) dut_al (
    .clk(clk), .rst(rst), .value_in(value_in), .dp_in(dp_in), .blank_in(blank_in),
    .lz_en(lz_en), .load(load), .update_pending(upd2), .frame_pulse(fp2),
    .seg_out(seg2), .an_out(an2));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] dp, input logic [3:0] bl, input logic lz);
    value_in = v;
    dp_in = dp;
    blank_in = bl;
    lz_en = lz;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic wait_frame();
    int n = 0;
    do begin
      upd_before = update_pending;
      @(negedge clk);
      n++;
    end while (!frame_pulse && n < 40);
    chk("frame_seen", 32'(frame_pulse), 1);
  endtask

  task automatic show_frame(input logic [7:0] s3, input logic [7:0] s2, input logic [7:0] s1, input logic [7:0] s0);
    logic [7:0] e [4];
    e[0] = s0;
    e[1] = s1;
    e[2] = s2;
    e[3] = s3;
    chk("fp_start", 32'(frame_pulse), 1);
    for (int j = 1; j <= 32; j++) begin
      int c, d;
      @(negedge clk);
      c = (j - 1) % 8;
      d = (j - 1) / 8;
      if (j == 1) chk("fp_low", 32'(frame_pulse), 0);
      if (c == 1) chk("an_blank", 32'(an_out), 0);
      if (c == 2 || c == 7) begin
        chk("an_slot", 32'(an_out), 32'(1) << d);
        chk("seg_slot", 32'(seg_out), 32'(e[d]));
      end
    end
    chk("fp_period", 32'(frame_pulse), 1);
  endtask

  initial begin
    cyc(3);
    chk("rst_seg", 32'(seg_out), 32'h00);
    chk("rst_an", 32'(an_out), 32'h0);
    chk("rst_upd", 32'(update_pending), 0);
    chk("rst_fp", 32'(frame_pulse), 0);
    chk("rst_seg_al", 32'(seg2), 32'hFF);
    chk("rst_an_al", 32'(an2), 32'hF);
    rst = 1'b0;
    cyc(2);
    chk("first_an_off", 32'(an_out), 32'h0);
    cyc(1);
    chk("first_an_on", 32'(an_out), 32'h1);
    chk("first_seg", 32'(seg_out), 32'h3F);
    do_load(16'h12AF, 4'h0, 4'h0, 1'b0);
    chk("load_upd", 32'(update_pending), 1);
    wait_frame();
    chk("commit_upd", 32'(update_pending), 0);
    show_frame(8'h06, 8'h5B, 8'h77, 8'h71);
    cyc(1);
    do_load(16'h1111, 4'h0, 4'h0, 1'b0);
    cyc(3);
    do_load(16'h2222, 4'h0, 4'h0, 1'b0);
    chk("dbl_upd", 32'(update_pending), 1);
    wait_frame();
    chk("upd_before_wrap", 32'(upd_before), 1);
    chk("upd_after_wrap", 32'(update_pending), 0);
    show_frame(8'h5B, 8'h5B, 8'h5B, 8'h5B);
    cyc(5);
    do_load(16'h3333, 4'h0, 4'h0, 1'b0);
    chk("pre_wrap_upd", 32'(update_pending), 1);
    cyc(25);
    do_load(16'h4444, 4'h0, 4'h0, 1'b0);
    chk("wrap_load_fp", 32'(frame_pulse), 1);
    chk("wrap_load_upd", 32'(update_pending), 1);
    show_frame(8'h4F, 8'h4F, 8'h4F, 8'h4F);
    chk("late_commit_upd", 32'(update_pending), 0);
    show_frame(8'h66, 8'h66, 8'h66, 8'h66);
    cyc(1);
    do_load(16'h0050, 4'h0, 4'h0, 1'b1);
    wait_frame();
    show_frame(8'h00, 8'h00, 8'h6D, 8'h3F);
    cyc(1);
    do_load(16'h0000, 4'h0, 4'h0, 1'b1);
    wait_frame();
    show_frame(8'h00, 8'h00, 8'h00, 8'h3F);
    cyc(1);
    do_load(16'h8888, 4'b0100, 4'b0001, 1'b0);
    wait_frame();
    show_frame(8'h7F, 8'hFF, 8'h7F, 8'h00);
    cyc(9);
    do_load(16'h5555, 4'hF, 4'h0, 1'b0);
    chk("mid_upd", 32'(update_pending), 1);
    cyc(1);
    chk("an_before_rst", 32'(an_out), 32'h2);
    rst = 1'b1;
    cyc(1);
    chk("mid_rst_seg", 32'(seg_out), 32'h00);
    chk("mid_rst_an", 32'(an_out), 32'h0);
    chk("mid_rst_upd", 32'(update_pending), 0);
    chk("mid_rst_fp", 32'(frame_pulse), 0);
    chk("mid_rst_seg_al", 32'(seg2), 32'hFF);
    chk("mid_rst_an_al", 32'(an2), 32'hF);
    cyc(1);
    rst = 1'b0;
    cyc(3);
    chk("post_rst_an", 32'(an_out), 32'h1);
    chk("post_rst_seg", 32'(seg_out), 32'h3F);
    chk("post_rst_an_al", 32'(an2), 32'hE);
    chk("post_rst_seg_al", 32'(seg2), 32'hC0);
    wait_frame();
    chk("post_rst_upd", 32'(update_pending), 0);
    show_frame(8'h3F, 8'h3F, 8'h3F, 8'h3F);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
